// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci index finder.
package fib_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } fib_state_t;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_IDX_W = 8;

    // Largest n with F(n) representable in 'width' bits (24 for width 16).
    function automatic int max_fib_index(input int width);
        longint a;
        longint b;
        longint c;
        longint lim;
        int     n;
        a   = 0;
        b   = 1;
        n   = 0;
        lim = longint'(1) << width;
        while (b < lim) begin
            c = a + b;
            a = b;
            b = c;
            n = n + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/fib_step.sv
// Fibonacci pair registers: num1=F(idx), num2=F(idx+1), with load and advance.
module fib_step
    import fib_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDX_W = DEF_IDX_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             advance,
    output logic [WIDTH-1:0] num1,
    output logic [WIDTH:0]   num2,
    output logic [IDX_W-1:0] idx
);

    // One extra bit so the first value past WIDTH is seen as a carry, not a wrap.
    logic [WIDTH:0] sum;

    // Next Fibonacci value; num1 never exceeds the target, so it fits WIDTH bits.
    always_comb begin
        sum = {1'b0, num1} + num2;
    end

    // Pair and index registers; load restarts the sequence at F(0), F(1).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            num1 <= '0;
            num2 <= {{WIDTH{1'b0}}, 1'b1};
            idx  <= '0;
        end else if (load) begin
            num1 <= '0;
            num2 <= {{WIDTH{1'b0}}, 1'b1};
            idx  <= '0;
        end else if (advance) begin
            // Advance only happens when num2 <= target, so its top bit is clear here.
            num1 <= num2[WIDTH-1:0];
            num2 <= sum;
            idx  <= idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/fib_index_finder.sv
// Finds the largest n with F(n) <= din and flags exact Fibonacci targets.
//
//  state  | meaning
//  IDLE   | after reset, waiting for start
//  SEARCH | stepping one Fibonacci term per clock
//  DONE   | dout/is_fib valid, start restarts a search
module fib_index_finder
    import fib_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDX_W = DEF_IDX_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    input  logic             start,
    output logic             busy,
    output logic [IDX_W-1:0] dout,
    output logic             is_fib,
    output logic             done
);

    if (IDX_W < $clog2(max_fib_index(WIDTH) + 1)) begin : g_idx_w_check
        $error("IDX_W too narrow for the largest Fibonacci index at this WIDTH");
    end

    fib_state_t       state_q;
    fib_state_t       state_d;
    logic [WIDTH-1:0] tgt;
    logic [WIDTH-1:0] num1;
    logic [WIDTH:0]   num2;
    logic [IDX_W-1:0] idx;
    logic             accept;
    logic             advance;
    logic             terminate;

    fib_step #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_step (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (accept),
        .advance (advance),
        .num1    (num1),
        .num2    (num2),
        .idx     (idx)
    );

    // Stop when the next term passes the target or no longer fits WIDTH bits.
    always_comb begin
        terminate = num2[WIDTH] || (num2[WIDTH-1:0] > tgt);
    end

    // Next-state and step controls.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        advance = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = SEARCH;
                end
            end
            SEARCH: begin
                if (terminate) begin
                    state_d = DONE;
                end else begin
                    advance = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Target capture and result registers; results hold across a restart until the next terminate.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tgt    <= '0;
            dout   <= '0;
            is_fib <= 1'b0;
        end else begin
            if (accept) begin
                tgt <= din;
            end
            if (state_q == SEARCH && terminate) begin
                dout   <= idx;
                is_fib <= (num1 == tgt);
            end
        end
    end

    // Status flags follow the state directly, so done drops on the restart edge.
    always_comb begin
        busy = (state_q == SEARCH);
        done = (state_q == DONE);
    end

endmodule
